flash_audio_sequencer: RTL and testbench

Sequences 32-bit word reads from the flash audio store and delivers 16-bit samples to the audio output path, one sample per sample tick.
- Sits downstream of the keyboard music controller. Consumes its pause/restart commands plus a direction select, and the synchronized sample-rate tick.
- Owns the flash read master handshake and the play address, including wrap and reverse playback.

---
 rtl/flash_audio_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_flash_audio_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_audio_sequencer.sv
// flash_audio_sequencer
// Fetches 32-bit words from the flash audio store, one read at a time, and
// plays each word out as two 16-bit samples on successive sample ticks.
// Handles forward/backward playback with wrap inside [START_ADDR, END_ADDR],
// pause, restart and underrun reporting.
module flash_audio_sequencer #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              pause,
    input  logic              restart,
    input  logic              direction,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_address,
    input  logic              flash_waitrequest,
    input  logic [31:0]       flash_readdata,
    input  logic              flash_readdatavalid,
    output logic [15:0]       audio_data,
    output logic              audio_valid,
    output logic              underrun
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_PLAY0,
        S_PLAY1,
        S_ADVANCE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    // Direction captured when a word starts playing; both halves use it.
    logic              dir_q, dir_d;
    logic              restart_pend_q, restart_pend_d;
    logic [15:0]       audio_data_q, audio_data_d;
    logic              audio_valid_q, audio_valid_d;
    logic              underrun_q, underrun_d;

    // A tick only matters while playback is not paused.
    logic              tick_live;
    assign tick_live = sample_tick & ~pause;

    // Next-state and output computation; everything defaults to holding.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        word_d         = word_q;
        dir_d          = dir_q;
        restart_pend_d = restart_pend_q;
        audio_data_d   = audio_data_q;
        audio_valid_d  = 1'b0;
        underrun_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (restart) begin
                    restart_pend_d = 1'b1;
                end
                if (!pause) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // The request is never aborted; a restart is only remembered.
                if (restart) begin
                    restart_pend_d = 1'b1;
                end
                if (tick_live) begin
                    underrun_d = 1'b1;
                end
                if (!flash_waitrequest) begin
                    state_d = S_WAIT_DATA;
                end
            end

            S_WAIT_DATA: begin
                if (restart) begin
                    restart_pend_d = 1'b1;
                end
                if (tick_live) begin
                    underrun_d = 1'b1;
                end
                if (flash_readdatavalid) begin
                    word_d = flash_readdata;
                    // A restart seen at any point of this fetch discards the word.
                    if (restart_pend_q || restart) begin
                        state_d = S_ADVANCE;
                    end else begin
                        dir_d   = direction;
                        state_d = S_PLAY0;
                    end
                end
            end

            S_PLAY0: begin
                if (restart) begin
                    restart_pend_d = 1'b1;
                    state_d        = S_ADVANCE;
                end else if (tick_live) begin
                    audio_data_d  = dir_q ? word_q[15:0] : word_q[31:16];
                    audio_valid_d = 1'b1;
                    state_d       = S_PLAY1;
                end
            end

            S_PLAY1: begin
                if (restart) begin
                    restart_pend_d = 1'b1;
                    state_d        = S_ADVANCE;
                end else if (tick_live) begin
                    audio_data_d  = dir_q ? word_q[31:16] : word_q[15:0];
                    audio_valid_d = 1'b1;
                    state_d       = S_ADVANCE;
                end
            end

            S_ADVANCE: begin
                if (tick_live) begin
                    underrun_d = 1'b1;
                end
                if (restart_pend_q) begin
                    addr_d = direction ? START_ADDR : END_ADDR;
                end else if (direction) begin
                    addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_ONE;
                end else begin
                    addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_ONE;
                end
                // A restart arriving now is applied at the following advance.
                restart_pend_d = restart;
                state_d        = S_REQ;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            addr_q         <= START_ADDR;
            word_q         <= 32'd0;
            dir_q          <= 1'b1;
            restart_pend_q <= 1'b0;
            audio_data_q   <= 16'd0;
            audio_valid_q  <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            word_q         <= word_d;
            dir_q          <= dir_d;
            restart_pend_q <= restart_pend_d;
            audio_data_q   <= audio_data_d;
            audio_valid_q  <= audio_valid_d;
            underrun_q     <= underrun_d;
        end
    end

    // Read request follows the state directly so it drops as soon as the
    // request is accepted or a reset lands.
    assign flash_read    = (state_q == S_REQ);
    assign flash_address = addr_q;
    assign audio_data    = audio_data_q;
    assign audio_valid   = audio_valid_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Randomized scoreboard bench for flash_audio_sequencer. The bench plays the
// flash slave, predicts the address sequence and sample stream from the
// playback rules, and a separate monitor checks every output cycle.
module tb_flash_audio_sequencer;

    localparam int          ADDR_W  = 23;
    localparam logic [22:0] START_A = 23'h000004;
    localparam logic [22:0] END_A   = 23'h00000B;
    localparam int          REGION  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        pause = 1'b1;
    logic        restart = 1'b0;
    logic        direction = 1'b1;
    logic        flash_read;
    logic [22:0] flash_address;
    logic        flash_waitrequest = 1'b1;
    logic [31:0] flash_readdata = 32'd0;
    logic        flash_readdatavalid = 1'b0;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        underrun;

    flash_audio_sequencer #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(START_A),
        .END_ADDR  (END_A)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .sample_tick        (sample_tick),
        .pause              (pause),
        .restart            (restart),
        .direction          (direction),
        .flash_read         (flash_read),
        .flash_address      (flash_address),
        .flash_waitrequest  (flash_waitrequest),
        .flash_readdata     (flash_readdata),
        .flash_readdatavalid(flash_readdatavalid),
        .audio_data         (audio_data),
        .audio_valid        (audio_valid),
        .underrun           (underrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          samples_seen = 0;

    // Scoreboard and reference model state
    logic [15:0] exp_q[$];
    logic [15:0] last_sample = 16'd0;
    logic [15:0] e_s;
    logic        mon_en = 1'b0;
    logic        evt_expected = 1'b0;
    logic [31:0] mem [16];
    logic [22:0] exp_addr = START_A;
    logic [22:0] req_addr = START_A;
    bit          outstanding = 0;
    bit          req_seen = 0;
    bit          discard = 0;
    bit          play_pend = 0;
    bit          started = 0;
    int          play_left = 0;
    int          wait_left = 0;
    int          lat_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Region arithmetic: position inside the region modulo its size.
    function automatic logic [22:0] step_addr(input logic [22:0] a, input logic fwd);
        int off;
        off = int'(a - START_A);
        off = fwd ? (off + 1) % REGION : (off + REGION - 1) % REGION;
        return START_A + 23'(off);
    endfunction

    function automatic logic [22:0] start_of(input logic fwd);
        return fwd ? START_A : END_A;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        last_sample = 16'd0;
        exp_addr    = START_A;
        outstanding = 0;
        req_seen    = 0;
        discard     = 0;
        play_pend   = 0;
        play_left   = 0;
        started     = 0;
    endtask

    // Monitor: checks outputs 1 time unit after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                check("tick_response", 32'(audio_valid) + 32'(underrun), 32'(evt_expected));
                if (audio_valid) begin
                    samples_seen++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sample_pop: got %0h expected no sample at %0t", audio_data, $time);
                    end else begin
                        e_s = exp_q.pop_front();
                        check("sample", 32'(audio_data), 32'(e_s));
                        last_sample = e_s;
                    end
                end else begin
                    check("audio_hold", 32'(audio_data), 32'(last_sample));
                end
            end
        end
    end

    // Random stimulus phase: flash slave with random wait/latency, random
    // ticks, pause stretches, restarts and direction changes.
    task automatic run_random(input int cycles, input int pause_pct);
        logic [31:0] w;
        bit          restart_in_play;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            restart             = 1'b0;
            sample_tick         = 1'b0;
            flash_readdatavalid = 1'b0;
            flash_waitrequest   = 1'b1;
            restart_in_play     = 0;
            if (play_pend) begin
                play_left = 2;
                play_pend = 0;
            end
            if ($urandom_range(0, 19) == 0) begin
                pause = ($urandom_range(0, 99) < pause_pct);
            end

            if (outstanding) begin
                check("read_dropped", 32'(flash_read), 32'd0);
                if (!discard && $urandom_range(0, 11) == 0) begin
                    restart = 1'b1;
                    discard = 1;
                end
                if (lat_left == 0) begin
                    w                   = mem[req_addr[3:0]];
                    flash_readdata      = w;
                    flash_readdatavalid = 1'b1;
                    outstanding         = 0;
                    if (discard) begin
                        exp_addr = start_of(direction);
                        discard  = 0;
                    end else begin
                        if (direction) begin
                            exp_q.push_back(w[15:0]);
                            exp_q.push_back(w[31:16]);
                        end else begin
                            exp_q.push_back(w[31:16]);
                            exp_q.push_back(w[15:0]);
                        end
                        exp_addr  = step_addr(req_addr, direction);
                        play_pend = 1;
                    end
                end else begin
                    lat_left--;
                end
            end else if (flash_read) begin
                started = 1;
                if (!req_seen) begin
                    req_seen  = 1;
                    wait_left = $urandom_range(0, 5);
                    if ($urandom_range(0, 3) == 0) begin
                        direction = ~direction;
                    end
                end
                check("req_address", 32'(flash_address), 32'(exp_addr));
                if (!discard && $urandom_range(0, 11) == 0) begin
                    restart = 1'b1;
                    discard = 1;
                end
                if (wait_left == 0) begin
                    flash_waitrequest = 1'b0;
                    outstanding       = 1;
                    req_seen          = 0;
                    req_addr          = exp_addr;
                    lat_left          = $urandom_range(0, 3);
                end else begin
                    wait_left--;
                end
            end else if (req_seen) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_held: got flash_read 0 expected 1 at %0t", $time);
                req_seen = 0;
            end else if (play_left > 0 && $urandom_range(0, 11) == 0) begin
                restart         = 1'b1;
                restart_in_play = 1;
                exp_q.delete();
                play_left = 0;
                exp_addr  = start_of(direction);
            end

            if (started && $urandom_range(0, 2) == 0) begin
                sample_tick = 1'b1;
            end
            evt_expected = sample_tick && !pause && !restart_in_play;
            if (evt_expected && play_left > 0) begin
                play_left--;
            end
        end
        @(negedge clk);
        evt_expected = 1'b0;
        sample_tick  = 1'b0;
        restart      = 1'b0;
        flash_readdatavalid = 1'b0;
        flash_waitrequest   = 1'b1;
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
        end
        mem[4] = 32'hBBBB_AAAA;

        // Power-on reset
        reset_n = 1'b0;
        pause   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_read", 32'(flash_read), 32'd0);
        check("rst_addr", 32'(flash_address), 32'(START_A));
        check("rst_audio", 32'(audio_data), 32'd0);
        check("rst_valid", 32'(audio_valid), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset_n = 1'b1;

        // Paused in idle: no request may be issued
        repeat (4) begin
            @(negedge clk);
            check("idle_paused_read", 32'(flash_read), 32'd0);
        end
        model_reset();
        mon_en = 1'b1;
        run_random(1500, 30);

        // Mid-operation reset while a request is being held off
        mon_en = 1'b0;
        pause  = 1'b0;
        got    = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            flash_waitrequest   = 1'b1;
            flash_readdatavalid = 1'b1;
            sample_tick         = 1'b1;
            if (flash_read) got = 1;
        end
        flash_readdatavalid = 1'b0;
        sample_tick         = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL reach_req: got no request expected one within 60 cycles");
        end
        repeat (3) begin
            @(negedge clk);
            check("req_hold_read", 32'(flash_read), 32'd1);
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_read", 32'(flash_read), 32'd0);
        check("midrst_addr", 32'(flash_address), 32'(START_A));
        check("midrst_audio", 32'(audio_data), 32'd0);
        check("midrst_valid", 32'(audio_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        run_random(1500, 20);

        check("progress", (samples_seen >= 100) ? 32'd1 : 32'd0, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
